piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in/serial-out transmitter. Opposite direction of the existing serial-in/parallel-out shift register.
- Accepts a WIDTH-bit word through a valid/ready load handshake, then shifts it out one bit per shift_en pulse.
- Asserts frame while a word is on the line and pulses done after the last bit.
- Sits next to the clock-divider tick in the board top. Its serial_out can be looped back into the receive shift register.

Parameters:
- WIDTH, 8, word length in bits (>=2).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- IDLE_LEVEL, 1'b0, value driven on serial_out when no word is in flight.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  word to transmit; sampled only on an accepted load.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  transmitter can accept a word this cycle (combinational).
- shift_en  input  1  single-cycle bit tick; advances one bit per cycle it is high.
- serial_out  output  1  current serial bit (registered).
- frame  output  1  high while a word is being transmitted.
- bit_cnt  output  $clog2(WIDTH)  index of the bit currently on serial_out (0 = first bit).
- done  output  1  one-cycle pulse after the final bit's shift edge.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, shift register=0, bit_cnt=0, frame=0, done=0, serial_out=IDLE_LEVEL.
  - A word in flight is discarded.
  - load_ready=1 as soon as reset is released.
- States: IDLE, SHIFT.
- load_ready = (state==IDLE) | (state==SHIFT & shift_en & bit_cnt==WIDTH-1).
- Accept = load_valid & load_ready at a clk edge:
  - shift register <= data_in; bit_cnt <= 0; state <= SHIFT; frame <= 1.
  - First bit appears on serial_out in the cycle after the accept edge.
  - Latency: 1 cycle.
- SHIFT, shift_en=1, bit_cnt<WIDTH-1:
  - Shift toward the output end, zero-fill; bit_cnt <= bit_cnt+1.
  - Each bit is held from one shift edge to the next, regardless of how many shift_en=0 cycles intervene.
- SHIFT, shift_en=1, bit_cnt==WIDTH-1:
  - done <= 1 for exactly one cycle.
  - With no simultaneous accept: state <= IDLE, frame <= 0, serial_out <= IDLE_LEVEL, bit_cnt <= 0.
  - With a simultaneous accept: load the new word and stay in SHIFT with frame=1. This gives gapless back-to-back words; done still pulses.
- SHIFT, shift_en=0: hold all state.
- IDLE: shift_en is ignored; done=0.
- A shift_en on the accept edge does not advance the new word; bit 0 of the frame lasts until the next shift_en.
- load_valid while load_ready=0: no effect. The producer must hold data_in/load_valid until accepted.
- serial_out = selected end of the shift register while frame=1, else IDLE_LEVEL. It is registered and never glitches from data_in.
- With shift_en held high, one word occupies exactly WIDTH cycles of frame.

Decomposition:
- Shared package (piso_pkg):
  - state encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - CNT_W derivation function (clog2 wrapper) for reuse by the receive-side shift register.
- No sub-module. The block is one FSM plus a counter and shift register.
- The bit tick comes from the existing clock divider (pulse form) in the top level.

Test Plan:
1. Reset and idle: hold rst_n=0 for 3 cycles, release with load_valid=0 -> serial_out=0, frame=0, done=0, load_ready=1 for 10 cycles.
2. MSB-first word, continuous tick: WIDTH=8, MSB_FIRST=1, shift_en=1, load 8'hA5.
   - serial_out = 1,0,1,0,0,1,0,1 on cycles 1..8 after accept; bit_cnt = 0..7.
   - done=1 in cycle 9 only; frame 1 on cycles 1..8, 0 on cycle 9.
3. Sparse tick, LSB first: MSB_FIRST=0, shift_en every 4th cycle, load 8'h3C.
   - Bits 0,0,1,1,1,1,0,0, each held for 4 cycles (bit 0 until the first shift_en).
   - frame spans 32 cycles; single done pulse.
4. Back-to-back: load_valid held high with 8'hF0 then 8'h0F, shift_en=1.
   - load_ready=1 on the last-bit cycle of word 1; 16 contiguous frame cycles with bit stream 11110000 00001111.
   - done pulses twice; no idle gap.
5. Reset mid-word: load 8'hFF, deassert rst_n after 3 bits -> serial_out=0, frame=0, bit_cnt=0 immediately (async).
   - After release, no done pulse and no residual bits.
6. Loopback: serial_out feeds the receive shift register, clocked with shift_en & frame, for 8'h5A, 8'h81, 8'h00 -> receiver parallel output equals each loaded word on that word's done cycle.

Source files
------------

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and counter-width helper for the shift-register pair
package piso_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Bit-index width for a WIDTH-bit word; never below 1 so a 2-bit word still has a counter.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// rtl/piso_tx_if.sv - valid/ready word-load handshake between producer and transmitter
interface piso_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;

  modport master (output data_in, output load_valid, input load_ready);
  modport slave  (input data_in, input load_valid, output load_ready);
endinterface

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in/serial-out transmitter with gapless back-to-back loads
module piso_tx
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  piso_tx_if.slave                  load,
  input  logic                      shift_en,
  output logic                      serial_out,
  output logic                      frame,
  output logic [cnt_w(WIDTH)-1:0]   bit_cnt,
  output logic                      done
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic [0:0]       state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             frame_nx;
  logic             out_nx;
  logic             last;
  logic             accept;

  assign last   = (state == ST_SHIFT) && shift_en && (bit_cnt == CNT_W'(WIDTH - 1));
  assign load.load_ready = (state == ST_IDLE) || last;
  assign accept = load.load_valid && load.load_ready;

  // Accept takes priority over the last-bit return to idle so words run back to back.
  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = bit_cnt;
    frame_nx = frame;
    if (accept) begin
      state_nx = ST_SHIFT;
      sreg_nx  = load.data_in;
      cnt_nx   = '0;
      frame_nx = 1'b1;
    end else if (last) begin
      state_nx = ST_IDLE;
      sreg_nx  = '0;
      cnt_nx   = '0;
      frame_nx = 1'b0;
    end else if (state == ST_SHIFT && shift_en) begin
      if (MSB_FIRST != 0) begin
        sreg_nx = {sreg[WIDTH-2:0], 1'b0};
      end else begin
        sreg_nx = {1'b0, sreg[WIDTH-1:1]};
      end
      cnt_nx = bit_cnt + 1'b1;
    end
  end

  // serial_out is computed from next-state so it is a clean register, never a data_in path.
  always_comb begin
    out_nx = IDLE_LEVEL;
    if (frame_nx) begin
      out_nx = (MSB_FIRST != 0) ? sreg_nx[WIDTH-1] : sreg_nx[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      frame      <= 1'b0;
      done       <= 1'b0;
      serial_out <= IDLE_LEVEL;
    end else begin
      state      <= state_nx;
      sreg       <= sreg_nx;
      bit_cnt    <= cnt_nx;
      frame      <= frame_nx;
      done       <= last;
      serial_out <= out_nx;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - scoreboard bench for piso_tx in MSB-first and LSB-first builds
module tb_piso_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(8)) if_m ();
  piso_tx_if #(.WIDTH(8)) if_l ();

  logic       shift_m, shift_l;
  logic       so_m, fr_m, dn_m, so_l, fr_l, dn_l;
  logic [2:0] bc_m, bc_l;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .load(if_m.slave), .shift_en(shift_m),
    .serial_out(so_m), .frame(fr_m), .bit_cnt(bc_m), .done(dn_m)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .load(if_l.slave), .shift_en(shift_l),
    .serial_out(so_l), .frame(fr_l), .bit_cnt(bc_l), .done(dn_l)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected {bit index, bit} per shift cycle and expected word per done pulse.
  int         bq_m[$], bq_l[$];
  logic [7:0] wq_m[$], wq_l[$];
  logic [7:0] rx_m = '0, rx_l = '0;
  int         done_m = 0, done_l = 0;

  // Receive shift registers clocked by shift_en & frame, fed from serial_out.
  always @(posedge clk) begin
    if (fr_m && shift_m) rx_m <= {rx_m[6:0], so_m};
    if (fr_l && shift_l) rx_l <= {so_l, rx_l[7:1]};
  end

  always @(negedge clk) begin
    int e;
    if (rst_n) begin
      if (fr_m && shift_m) begin
        if (bq_m.size() == 0) check("m_bit_unexpected", bq_m.size(), 1);
        else begin
          e = bq_m.pop_front();
          check("m_serial_out", so_m, e & 1);
          check("m_bit_cnt", bc_m, e >> 1);
        end
      end
      if (dn_m) begin
        done_m++;
        if (wq_m.size() == 0) check("m_done_unexpected", wq_m.size(), 1);
        else check("m_loopback", rx_m, wq_m.pop_front());
      end
      if (fr_l && shift_l) begin
        if (bq_l.size() == 0) check("l_bit_unexpected", bq_l.size(), 1);
        else begin
          e = bq_l.pop_front();
          check("l_serial_out", so_l, e & 1);
          check("l_bit_cnt", bc_l, e >> 1);
        end
      end
      if (dn_l) begin
        done_l++;
        if (wq_l.size() == 0) check("l_done_unexpected", wq_l.size(), 1);
        else check("l_loopback", rx_l, wq_l.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word, wait (bounded) for load_ready, push expectations, return 1 ns after the accept edge.
  task automatic send(input int sel, input logic [7:0] w, input bit keep_valid, output int waited);
    logic rdy;
    int   n;
    n = 0;
    if (sel == 0) begin if_m.data_in = w; if_m.load_valid = 1'b1; end
    else          begin if_l.data_in = w; if_l.load_valid = 1'b1; end
    do begin
      @(negedge clk);
      rdy = (sel == 0) ? if_m.load_ready : if_l.load_ready;
      n++;
    end while (!rdy && n < 50);
    waited = n;
    if (!rdy) check("send_ready_timeout", rdy, 1);
    for (int i = 0; i < 8; i++) begin
      if (sel == 0) bq_m.push_back(i * 2 + w[7 - i]);
      else          bq_l.push_back(i * 2 + w[i]);
    end
    if (sel == 0) wq_m.push_back(w);
    else          wq_l.push_back(w);
    tick();
    if (!keep_valid) begin
      if (sel == 0) if_m.load_valid = 1'b0;
      else          if_l.load_valid = 1'b0;
    end
  endtask

  initial begin
    int          w;
    int          cnt;
    int          d0;
    logic [7:0]  word;
    logic [7:0]  words [3];

    if_m.data_in = '0; if_m.load_valid = 1'b0; shift_m = 1'b0;
    if_l.data_in = '0; if_l.load_valid = 1'b0; shift_l = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_serial_out", so_m, 0);
    check("rst_frame", fr_m, 0);
    check("rst_bit_cnt", bc_m, 0);
    check("rst_done", dn_m, 0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_serial_out", so_m, 0);
      check("idle_frame", fr_m, 0);
      check("idle_done", dn_m, 0);
      check("idle_ready_m", if_m.load_ready, 1);
      check("idle_ready_l", if_l.load_ready, 1);
    end
    tick();

    // MSB-first, continuous tick
    shift_m = 1'b1;
    send(0, 8'hA5, 0, w);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("a5_frame", fr_m, (k <= 8));
      check("a5_done", dn_m, (k == 9));
      check("a5_ready", if_m.load_ready, (k >= 8));
      tick();
    end
    shift_m = 1'b0;
    repeat (3) tick();

    // LSB-first, shift_en every 4th cycle
    send(1, 8'h3C, 0, w);
    word = 8'h3C;
    cnt = 0;
    d0 = done_l;
    for (int k = 0; k < 40; k++) begin
      shift_l = ((k % 4) == 3);
      @(negedge clk);
      check("3c_frame", fr_l, (k < 32));
      if (k < 32) check("3c_hold", so_l, word[k / 4]);
      else        check("3c_idle_out", so_l, 0);
      if (fr_l) cnt++;
      tick();
    end
    shift_l = 1'b0;
    check("3c_frame_len", cnt, 32);
    check("3c_done_count", done_l - d0, 1);

    // Back-to-back words with load_valid held
    shift_m = 1'b1;
    d0 = done_m;
    send(0, 8'hF0, 1, w);
    send(0, 8'h0F, 0, w);
    check("b2b_ready_at_last_bit", w, 8);
    for (int k = 9; k <= 17; k++) begin
      @(negedge clk);
      check("b2b_frame", fr_m, (k <= 16));
      check("b2b_done", dn_m, (k == 9 || k == 17));
      tick();
    end
    check("b2b_done_count", done_m - d0, 2);
    shift_m = 1'b0;
    repeat (3) tick();

    // Async reset mid-word
    shift_m = 1'b1;
    d0 = done_m;
    send(0, 8'hFF, 0, w);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_serial_out", so_m, 0);
    check("midrst_frame", fr_m, 0);
    check("midrst_bit_cnt", bc_m, 0);
    bq_m.delete();
    wq_m.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("postrst_done", dn_m, 0);
      check("postrst_frame", fr_m, 0);
      check("postrst_serial_out", so_m, 0);
      tick();
    end
    check("postrst_done_count", done_m - d0, 0);

    // Loopback through the receive shift register
    words[0] = 8'h5A; words[1] = 8'h81; words[2] = 8'h00;
    d0 = done_m;
    for (int i = 0; i < 3; i++) begin
      send(0, words[i], 0, w);
      repeat (12) tick();
    end
    check("loop_done_count", done_m - d0, 3);
    shift_m = 1'b0;

    check("m_bits_left", bq_m.size(), 0);
    check("m_words_left", wq_m.size(), 0);
    check("l_bits_left", bq_l.size(), 0);
    check("l_words_left", wq_l.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
